// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - boot-load controller: streams words into imem, gates core reset, keeps a checksum
module imem_load_ctrl #(
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int ADDR_W          = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              boot_skip,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt,
    output logic [31:0]       checksum
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    // Largest legal length, expressed in the width of load_len.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH_WORDS);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [31:0]       sum_q, sum_d;
    logic              err_q, err_d;
    logic              len_legal;
    logic              beat;

    assign len_legal = (load_len != '0) && (load_len <= DEPTH_L);

    // Stream handshake and write port; ready only while loading so
    // stray valids in other states can never reach imem.
    assign s_ready    = (state_q == ST_LOAD);
    assign beat       = s_valid && s_ready;
    assign imem_we    = beat;
    assign imem_waddr = cnt_q[ADDR_W-1:0];
    assign imem_wdata = s_data;

    assign busy      = (state_q == ST_LOAD);
    assign done      = (state_q == ST_RELEASE);
    assign cpu_rst_n = (state_q == ST_RUN);
    assign err       = err_q;
    assign word_cnt  = cnt_q;
    assign checksum  = sum_q;

    // Next-state logic: start requests are honoured only in IDLE and RUN;
    // an illegal length flags err and leaves everything else alone.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    if (len_legal) begin
                        len_d   = load_len;
                        cnt_d   = '0;
                        sum_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (boot_skip && (state_q == ST_IDLE)) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    sum_d = sum_q + s_data;
                    if (cnt_q == (len_q - 1'b1)) begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - randomized self-checking bench for imem_load_ctrl
module tb_imem_load_ctrl;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          boot_skip;
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_cnt;
    logic [31:0]   checksum;

    imem_load_ctrl #(.MEM_DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_len   (load_len),
        .boot_skip  (boot_skip),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_cnt   (word_cnt),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural imem fed by the DUT write port, plus the image we expect in it.
    logic [31:0] tb_mem  [DEPTH];
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] data_q  [$];
    logic [31:0] exp_sum;
    int          exp_cnt;

    always @(posedge clk) begin
        if (imem_we) tb_mem[imem_waddr] <= imem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_s_ready", s_ready, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_checksum", checksum, 0);
        check("rst_waddr", imem_waddr, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; load_start = 1'b0; boot_skip = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
    endtask

    // Present a start request for one edge; returns at the following negedge.
    task automatic start(input int len, input bit skip);
        @(negedge clk);
        load_start = 1'b1;
        load_len   = len[AW:0];
        boot_skip  = skip;
        @(negedge clk);
        load_start = 1'b0;
        boot_skip  = 1'b0;
    endtask

    // Drive up to 'beats' words; mode 0 = continuous, 1 = toggle 1/0, 2 = random.
    // Each write is checked against the address/data the spec rule dictates.
    task automatic stream(input int beats, input int mode);
        int  cyc = 0;
        bit  v;
        exp_sum = 0;
        exp_cnt = 0;
        while (exp_cnt < beats && cyc < 5000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            s_valid = v;
            if (v && data_q.size() > 0) s_data = data_q.pop_front();
            else                        s_data = $urandom;
            #1;
            check("ld_s_ready", s_ready, 1);
            check("ld_cpu_rst", cpu_rst_n, 0);
            check("ld_we", imem_we, v);
            if (v) begin
                check("ld_waddr", imem_waddr, exp_cnt);
                check("ld_wdata", imem_wdata, s_data);
            end
            @(posedge clk);
            if (v) begin
                exp_mem[exp_cnt] = s_data;
                exp_sum = exp_sum + s_data;
                exp_cnt++;
            end
            @(negedge clk);
            s_valid = 1'b0;
            cyc++;
        end
        if (exp_cnt < beats) check("stream_timeout", 0, 1);
    endtask

    // After the final beat: done pulse, then core released, counters held.
    task automatic check_completion(input int len);
        check("cmp_done", done, 1);
        check("cmp_cpu_rst_n0", cpu_rst_n, 0);
        check("cmp_s_ready", s_ready, 0);
        check("cmp_busy", busy, 0);
        check("cmp_word_cnt", word_cnt, len);
        check("cmp_checksum", checksum, exp_sum);
        @(negedge clk);
        check("run_done", done, 0);
        check("run_cpu_rst_n", cpu_rst_n, 1);
        check("run_word_cnt", word_cnt, len);
        check("run_checksum", checksum, exp_sum);
        for (int i = 0; i < len; i++) begin
            if (tb_mem[i] !== exp_mem[i]) check("mem_image", tb_mem[i], exp_mem[i]);
        end
        n_checks++;
    endtask

    task automatic full_load(input int len, input int mode);
        start(len, 1'b0);
        check("start_busy", busy, 1);
        check("start_err", err, 0);
        stream(len, mode);
        check_completion(len);
    endtask

    initial begin
        rst_n = 1'b0; load_start = 1'b0; load_len = '0; boot_skip = 1'b0;
        s_valid = 1'b0; s_data = '0;
        do_reset();

        // Known program, continuous beats.
        data_q = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193};
        full_load(4, 0);
        check("prog_checksum", checksum, 32'h0060834C);

        // Same image with valid toggling.
        do_reset();
        data_q = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193};
        full_load(4, 1);
        check("tog_checksum", checksum, 32'h0060834C);

        // Illegal lengths from IDLE, then a legal start clears err.
        do_reset();
        start(0, 1'b0);
        check("len0_err", err, 1);
        check("len0_s_ready", s_ready, 0);
        check("len0_busy", busy, 0);
        start(1025, 1'b0);
        check("len1025_err", err, 1);
        check("len1025_s_ready", s_ready, 0);
        check("len1025_cpu_rst", cpu_rst_n, 0);
        full_load(2, 2);

        // Reload from RUN with wrapping checksum.
        data_q = '{32'hFFFFFFFF, 32'h00000002};
        start(2, 1'b0);
        check("reload_cpu_rst_n", cpu_rst_n, 0);
        stream(2, 0);
        check_completion(2);
        check("reload_checksum", checksum, 32'h00000001);

        // Illegal start in RUN: err set, stays in RUN, counters untouched.
        start(1025, 1'b0);
        check("run_ill_err", err, 1);
        check("run_ill_cpu", cpu_rst_n, 1);
        check("run_ill_cnt", word_cnt, 2);
        check("run_ill_sum", checksum, 32'h00000001);

        // Reset in the middle of a load, then a one-word load hits address 0.
        do_reset();
        start(4, 1'b0);
        stream(2, 0);
        do_reset();
        full_load(1, 0);

        // boot_skip alone: released next cycle, no writes, no done.
        do_reset();
        @(negedge clk);
        boot_skip = 1'b1;
        s_valid   = 1'b1;
        @(negedge clk);
        boot_skip = 1'b0;
        check("skip_cpu_rst_n", cpu_rst_n, 1);
        check("skip_we", imem_we, 0);
        check("skip_done", done, 0);
        s_valid = 1'b0;

        // boot_skip with a legal start: start wins.
        do_reset();
        start(3, 1'b1);
        check("both_busy", busy, 1);
        check("both_cpu_rst", cpu_rst_n, 0);
        stream(3, 2);
        check_completion(3);

        // Maximum length load.
        full_load(DEPTH, 0);

        // Randomized loads back to back from RUN.
        for (int k = 0; k < 6; k++) begin
            full_load($urandom_range(1, 40), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
